// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the rr_mux stream multiplexer.
// Lock-state typedef is only exercised when RR_MUX_LOCK_EN is defined.
package rr_mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/rr_mux_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping to 0.
// Expects ptr < N_CH.
module rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W:0] c;
   logic           found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = '0;
      for (int k = 0; k < N_CH; k++) begin
         // one extra bit so ptr+k cannot overflow before the wrap
         c = {1'b0, ptr} + (SEL_W+1)'(k);
         if (c >= (SEL_W+1)'(N_CH)) c = c - (SEL_W+1)'(N_CH);
         if (!found && req[c[SEL_W-1:0]]) begin
            found = 1'b1;
            idx   = c[SEL_W-1:0];
         end
      end
      if (found) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/rr_mux.sv
// N-channel registered stream mux with explicit-select or round-robin arbitration.
// Optional packet lock (in_last/out_last ports) enabled by defining RR_MUX_LOCK_EN.
//
// state  | meaning
// IDLE   | arbitrate every beat
// LOCKED | mid-packet, grant pinned to lock_ch until a last beat transfers
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int WIDTH = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef RR_MUX_LOCK_EN
   ,
   input  logic [N_CH-1:0]       in_last,
   output logic                  out_last
`endif
);

   logic [WIDTH-1:0] ch_data [N_CH];
   logic [N_CH-1:0]  arb_gnt;
   logic [SEL_W-1:0] arb_idx;
   logic [SEL_W-1:0] ptr;
   logic [N_CH-1:0]  sel_vec;
   logic [N_CH-1:0]  g_vec;
   logic [SEL_W-1:0] g_idx;
   logic [SEL_W-1:0] ptr_nxt;
   logic             free;
   logic             xfer;
   logic             adv;

`ifdef RR_MUX_LOCK_EN
   lock_state_t      state_q, state_d;
   logic [SEL_W-1:0] lock_ch;
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
      .req (in_valid),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // out-of-range sel shifts the one-hot off the top and never grants
   assign sel_vec = ({1'b0, sel} < (SEL_W+1)'(N_CH)) ? (N_CH'(1) << sel) : '0;
   assign free    = !out_valid || out_ready;

   always_comb begin
      g_vec = '0;
      g_idx = '0;
      if (!reset) begin
`ifdef RR_MUX_LOCK_EN
         if (state_q == LOCKED) begin
            g_vec = (N_CH'(1) << lock_ch) & in_valid;
            g_idx = lock_ch;
         end else
`endif
         if (mode == MODE_RR) begin
            g_vec = arb_gnt;
            g_idx = arb_idx;
         end else begin
            g_vec = sel_vec & in_valid;
            g_idx = sel;
         end
      end
   end

   assign in_ready = free ? g_vec : '0;
   assign xfer     = free && (|g_vec);
   assign ptr_nxt  = (g_idx == SEL_W'(N_CH-1)) ? '0 : g_idx + SEL_W'(1);

`ifdef RR_MUX_LOCK_EN
   // pointer moves only when a packet closes, so a locked packet counts as one turn
   assign adv = xfer && in_last[g_idx] && ((state_q == LOCKED) || (mode == MODE_RR));

   always_comb begin
      state_d = state_q;
      if (xfer) begin
         case (state_q)
            IDLE:    if (!in_last[g_idx]) state_d = LOCKED;
            LOCKED:  if (in_last[g_idx])  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         lock_ch <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == LOCKED) lock_ch <= g_idx;
      end
   end
`else
   assign adv = xfer && (mode == MODE_RR);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (adv) begin
         ptr <= ptr_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
`ifdef RR_MUX_LOCK_EN
         out_last  <= 1'b0;
`endif
      end else if (xfer) begin
         out_data  <= ch_data[g_idx];
         out_ch    <= g_idx;
         out_valid <= 1'b1;
`ifdef RR_MUX_LOCK_EN
         out_last  <= in_last[g_idx];
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux: directed scenarios plus random traffic vs a beat-level model.
module tb_rr_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           mode = 1'b0;
   logic [1:0]     sel = '0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_ch;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [N-1:0]   in_last = '0;
   logic           out_last;

   // three-channel instance exercises a select value beyond N_CH
   logic [1:0]     b_sel = 2'd3;
   logic [3*W-1:0] b_data = {8'h77, 8'h66, 8'h55};
   logic [2:0]     b_valid = 3'b111;
   logic [2:0]     b_in_ready;
   logic [W-1:0]   b_out_data;
   logic [1:0]     b_out_ch;
   logic           b_out_valid;
   logic           b_out_last;

   int n_chk = 0;
   int n_bad = 0;

   // reference model state
   bit          m_valid;
   logic [W-1:0] m_data;
   int          m_ch;
   bit          m_last;
   int          m_ptr;
   bit          m_locked;
   int          m_lch;

   always #5 clock = ~clock;

   rr_mux #(.N_CH(N), .WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef RR_MUX_LOCK_EN
      ,
      .in_last   (in_last),
      .out_last  (out_last)
`endif
   );

   rr_mux #(.N_CH(3), .WIDTH(W)) dut_b (
      .clock     (clock),
      .reset     (reset),
      .mode      (1'b0),
      .sel       (b_sel),
      .in_data   (b_data),
      .in_valid  (b_valid),
      .in_ready  (b_in_ready),
      .out_data  (b_out_data),
      .out_ch    (b_out_ch),
      .out_valid (b_out_valid),
      .out_ready (1'b1)
`ifdef RR_MUX_LOCK_EN
      ,
      .in_last   (3'b111),
      .out_last  (b_out_last)
`endif
   );

`ifndef RR_MUX_LOCK_EN
   assign out_last   = 1'b0;
   assign b_out_last = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a negedge with inputs driven; returns at the next negedge.
   task automatic cycle();
      int         g;
      int         c;
      bit         free;
      bit         xfer;
      logic [N-1:0] exp_rdy;
      #1;
      free = !m_valid || out_ready;
      g = -1;
      if (!reset) begin
         if (m_locked) begin
            if (in_valid[m_lch]) g = m_lch;
         end else if (mode) begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (g < 0 && in_valid[c]) g = c;
            end
         end else if (int'(sel) < N && in_valid[sel]) begin
            g = int'(sel);
         end
      end
      xfer = (g >= 0) && free;
      exp_rdy = '0;
      if (xfer) exp_rdy[g] = 1'b1;
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_ch", out_ch, m_ch);
`ifdef RR_MUX_LOCK_EN
      chk("out_last", out_last, m_last);
`endif
      @(posedge clock);
      if (reset) begin
         m_valid = 0; m_data = '0; m_ch = 0; m_last = 0; m_ptr = 0; m_locked = 0; m_lch = 0;
      end else if (xfer) begin
         m_valid = 1;
         m_data  = in_data[g*W +: W];
         m_ch    = g;
`ifdef RR_MUX_LOCK_EN
         m_last  = in_last[g];
         if (in_last[g] && (m_locked || mode)) m_ptr = (g + 1) % N;
         if (!m_locked && !in_last[g]) begin
            m_locked = 1;
            m_lch    = g;
         end else if (m_locked && in_last[g]) begin
            m_locked = 0;
         end
`else
         if (mode) m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
         m_valid = 0;
      end
      @(negedge clock);
   endtask

   initial begin
      @(negedge clock);

      // reset held two cycles with every channel valid
      reset = 1; mode = 1; in_valid = '1; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      cycle();
      cycle();
      chk("rst_ov", out_valid, 0);
      chk("rst_data", out_data, 0);
      reset = 0;
      cycle();
      chk("first_ch", out_ch, 0);
      chk("first_data", out_data, 8'h11);

      // explicit select
      mode = 0; sel = 2; in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      cycle();
      chk("sel_data", out_data, 8'hA5);
      chk("sel_ch", out_ch, 2);

      // out-of-range select on the three-channel instance
      b_sel = 2'd3;
      #1 chk("oor_rdy", b_in_ready, 3'b000);
      @(posedge clock); #1;
      chk("oor_ov", b_out_valid, 0);
      b_sel = 2'd2;
      #1 chk("b_rdy", b_in_ready, 3'b100);
      @(posedge clock); #1;
      chk("b_data", b_out_data, 8'h77);
      @(negedge clock);
      // model holds no knowledge of the cycle spent on dut_b; resync with a reset
      reset = 1;
      cycle();
      reset = 0;

      // round-robin, all valid
      mode = 1; in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_all", out_ch, i % N);
      end
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_odd", out_ch, (i % 2) ? 3 : 1);
      end

      // backpressure
      mode = 0; sel = 0; in_valid = 4'b0001; in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
      cycle();
      out_ready = 0; in_data[7:0] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_hold", out_data, 8'h3C);
      end
      #1 chk("bp_rdy", in_ready, 4'b0000);
      out_ready = 1;
      cycle();
      chk("bp_reload", out_data, 8'h5A);
      chk("bp_ov", out_valid, 1);

`ifdef RR_MUX_LOCK_EN
      // packet lock: ch0 three beats while ch1 competes and mode toggles
      reset = 1; cycle(); reset = 0;
      mode = 1; in_valid = 4'b0011; in_last = 4'b0010;
      cycle();
      chk("lk_b1", out_ch, 0);
      mode = 0; sel = 1;
      cycle();
      chk("lk_b2", out_ch, 0);
      in_last = 4'b0011; mode = 1;
      cycle();
      chk("lk_b3", out_ch, 0);
      cycle();
      chk("lk_after", out_ch, 1);

      // reset while locked
      in_last = 4'b0000; in_valid = 4'b0100;
      cycle();
      reset = 1; cycle(); reset = 0;
      chk("lkrst_ov", out_valid, 0);
      in_valid = 4'b1111; mode = 1;
      cycle();
      chk("lkrst_ch", out_ch, 0);
`endif

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(99) == 0);
         mode      = ($urandom_range(3) != 0);
         sel       = 2'($urandom_range(3));
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         in_data   = 32'($urandom);
         out_ready = ($urandom_range(3) != 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
